// File: rtl/dcache_store_buffer_if.sv
// Bundle of every non-clock, non-reset signal of the dcache store buffer.
// slave  : the store buffer itself.
// master : the pipeline/dcache side (memory stage, load unit, dcache port).
// Groups: store request (st_*), load lookup (ld_*), dcache read/write
// port (dc_*), drain_stall back-pressure and the empty status flag.
interface dcache_store_buffer_if #(
  parameter int IDX_W = 11
);
  logic             st_valid;
  logic             st_ready;
  logic [63:0]      st_addr;
  logic [63:0]      st_data;
  logic [7:0]       st_be;
  logic             ld_valid;
  logic [63:0]      ld_addr;
  logic             ld_fwd_hit;
  logic [63:0]      ld_fwd_data;
  logic             ld_stall;
  logic [IDX_W-1:0] dc_rd_index;
  logic [63:0]      dc_rd_data;
  logic             dc_wr_en;
  logic [IDX_W-1:0] dc_wr_index;
  logic [63:0]      dc_wr_data;
  logic             drain_stall;
  logic             empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr,
           dc_rd_data, drain_stall,
    output st_ready, ld_fwd_hit, ld_fwd_data, ld_stall, dc_rd_index,
           dc_wr_en, dc_wr_index, dc_wr_data, empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr,
           dc_rd_data, drain_stall,
    input  st_ready, ld_fwd_hit, ld_fwd_data, ld_stall, dc_rd_index,
           dc_wr_en, dc_wr_index, dc_wr_data, empty
  );
endinterface

// File: rtl/dcache_store_buffer.sv
// Store buffer in front of the dcache write port.
// Stores from the memory stage are queued in a circular FIFO of DEPTH
// entries (word index, data, byte enables) and drained one per cycle into
// the dcache with a read-merge-write of the byte enables. Loads look the
// buffer up combinationally and either get the youngest full-word match
// forwarded or are told to retry on a partial overlap.
// Ports: clk, reset_n (synchronous, active-low), bus (slave modport of
// dcache_store_buffer_if carrying the store, load and dcache signals).
//
// Store handshake: a store transfers at a posedge where st_valid and
// st_ready are both high. st_ready depends only on the registered count
// (never on st_valid or on a drain in the same cycle), and the master must
// hold st_addr/st_data/st_be stable while st_valid is high and st_ready low.
module dcache_store_buffer #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dcache_store_buffer_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  typedef logic [PTR_W-1:0] ptr_t;

  logic [IDX_W-1:0] ent_idx  [DEPTH];
  logic [63:0]      ent_data [DEPTH];
  logic [7:0]       ent_be   [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  ptr_t             head;
  ptr_t             tail;
  logic [PTR_W:0]   count;

  logic [IDX_W-1:0] st_idx;
  logic [IDX_W-1:0] ld_idx;
  logic             not_full;
  logic             enq;
  logic             drain_go;
  logic             st_conflict;
  logic             ld_match;
  logic             ld_full;
  logic [63:0]      ld_data_sel;
  logic             fwd_hit;
  logic             unused_addr_bits;

  assign st_idx = bus.st_addr[IDX_W+2:3];
  assign ld_idx = bus.ld_addr[IDX_W+2:3];
  assign unused_addr_bits = ^{bus.st_addr[63:IDX_W+3], bus.st_addr[2:0],
                              bus.ld_addr[63:IDX_W+3], bus.ld_addr[2:0]};

  assign not_full = (count != FULL_CNT);
  // Everything is gated with reset_n so a cycle with reset low never
  // enqueues, drains or writes the dcache, and the outputs show the
  // reset values during that cycle as well as after it.
  assign enq      = reset_n && bus.st_valid && not_full;
  assign drain_go = reset_n && (count != '0) && !bus.drain_stall;

  assign bus.st_ready = !reset_n || not_full;
  assign bus.empty    = !reset_n || (count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_idx[i]  <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      // enq and drain never touch the same slot: drain needs count>0 and
      // enq needs count<DEPTH, so head==tail cannot occur with both set.
      if (enq) begin
        ent_idx[tail]   <= st_idx;
        ent_data[tail]  <= bus.st_data;
        ent_be[tail]    <= bus.st_be;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (drain_go) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({enq, drain_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drain path: the dcache read of the head word is combinational, so the
  // merged word is ready for the write in the same cycle.
  always_comb begin
    bus.dc_rd_index = ent_idx[head];
    bus.dc_wr_index = ent_idx[head];
    bus.dc_wr_en    = drain_go;
    bus.dc_wr_data  = '0;
    if (drain_go) begin
      for (int b = 0; b < 8; b++) begin
        bus.dc_wr_data[8*b +: 8] = ent_be[head][b] ? ent_data[head][8*b +: 8]
                                                   : bus.dc_rd_data[8*b +: 8];
      end
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest.
  // The head entry stays valid during its drain cycle and is included.
  always_comb begin
    ptr_t slot;
    slot        = '0;
    ld_match    = 1'b0;
    ld_full     = 1'b0;
    ld_data_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + ptr_t'(k);
      if (ent_valid[slot] && (ent_idx[slot] == ld_idx)) begin
        ld_match    = 1'b1;
        ld_full     = (ent_be[slot] == 8'hFF);
        ld_data_sel = ent_data[slot];
      end
    end
  end

  // A store to the same word arriving this cycle is not in the buffer yet,
  // so the load cannot see its data and must retry.
  assign st_conflict     = bus.st_valid && (st_idx == ld_idx);
  assign fwd_hit         = reset_n && bus.ld_valid && ld_match && ld_full && !st_conflict;
  assign bus.ld_fwd_hit  = fwd_hit;
  assign bus.ld_fwd_data = fwd_hit ? ld_data_sel : 64'd0;
  assign bus.ld_stall    = reset_n && bus.ld_valid &&
                           (st_conflict || (ld_match && !ld_full));
endmodule

// File: tb/tb_dcache_store_buffer.sv
module tb_dcache_store_buffer;
  localparam int DEPTH = 4;
  localparam int IDX_W = 11;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  dcache_store_buffer_if #(.IDX_W(IDX_W)) bus ();

  dcache_store_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic v, input logic [63:0] addr,
                             input logic [63:0] data, input logic [7:0] be);
    bus.st_valid = v;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_be    = be;
  endtask

  task automatic drive_load(input logic v, input logic [63:0] addr);
    bus.ld_valid = v;
    bus.ld_addr  = addr;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b0, 64'd0);
    bus.dc_rd_data  = 64'd0;
    bus.drain_stall = 1'b0;
    tick();
    // inputs active while in reset must be ignored
    drive_store(1'b1, 64'h40, 64'hDEADBEEFDEADBEEF, 8'hFF);
    drive_load(1'b1, 64'h40);
    #1;
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL rst_st_ready got=%0b exp=1", bus.st_ready); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b exp=0", bus.dc_wr_en); end
    checks++; if (bus.dc_wr_data !== 64'd0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", bus.dc_wr_data); end
    checks++; if (bus.ld_fwd_hit !== 1'b0) begin failures++; $display("FAIL rst_fwd_hit got=%0b exp=0", bus.ld_fwd_hit); end
    checks++; if (bus.ld_stall !== 1'b0) begin failures++; $display("FAIL rst_ld_stall got=%0b exp=0", bus.ld_stall); end
    checks++; if (bus.ld_fwd_data !== 64'd0) begin failures++; $display("FAIL rst_fwd_data got=%h exp=0", bus.ld_fwd_data); end
    tick();
    reset_n = 1'b1;
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b0, 64'd0);
    tick();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst_no_enq_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL rst_no_enq_wr_en got=%0b exp=0", bus.dc_wr_en); end
  endtask

  task automatic test_basic_store();
    drive_store(1'b1, 64'h40, 64'h1122334455667788, 8'hFF);
    #1;
    // no same-cycle pass-through
    checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%0b exp=0", bus.dc_wr_en); end
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL basic_st_ready got=%0b exp=1", bus.st_ready); end
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    #1;
    checks++; if (bus.dc_wr_en !== 1'b1) begin failures++; $display("FAIL basic_wr_en got=%0b exp=1", bus.dc_wr_en); end
    checks++; if (bus.dc_wr_index !== 11'd8) begin failures++; $display("FAIL basic_wr_index got=%0d exp=8", bus.dc_wr_index); end
    checks++; if (bus.dc_rd_index !== 11'd8) begin failures++; $display("FAIL basic_rd_index got=%0d exp=8", bus.dc_rd_index); end
    checks++; if (bus.dc_wr_data !== 64'h1122334455667788) begin failures++; $display("FAIL basic_wr_data got=%h exp=1122334455667788", bus.dc_wr_data); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL basic_not_empty got=%0b exp=0", bus.empty); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL basic_empty_after got=%0b exp=1", bus.empty); end
    checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL basic_idle_wr_en got=%0b exp=0", bus.dc_wr_en); end
    checks++; if (bus.dc_wr_data !== 64'd0) begin failures++; $display("FAIL basic_idle_wr_data got=%h exp=0", bus.dc_wr_data); end
  endtask

  task automatic test_merge();
    bus.dc_rd_data = 64'h1111111122222222;
    drive_store(1'b1, 64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    tick();
    // second store (be=0) enqueued while the first drains
    drive_store(1'b1, 64'h28, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    #1;
    checks++; if (bus.dc_wr_index !== 11'd2) begin failures++; $display("FAIL merge_index got=%0d exp=2", bus.dc_wr_index); end
    checks++; if (bus.dc_wr_data !== 64'h11111111BBBBBBBB) begin failures++; $display("FAIL merge_data got=%h exp=11111111bbbbbbbb", bus.dc_wr_data); end
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    #1;
    checks++; if (bus.dc_wr_en !== 1'b1) begin failures++; $display("FAIL be0_wr_en got=%0b exp=1", bus.dc_wr_en); end
    checks++; if (bus.dc_wr_index !== 11'd5) begin failures++; $display("FAIL be0_index got=%0d exp=5", bus.dc_wr_index); end
    checks++; if (bus.dc_wr_data !== 64'h1111111122222222) begin failures++; $display("FAIL be0_data got=%h exp=1111111122222222", bus.dc_wr_data); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL merge_empty got=%0b exp=1", bus.empty); end
    bus.dc_rd_data = 64'd0;
  endtask

  task automatic test_full_stall();
    logic [63:0] data_tab [5];
    for (int i = 0; i < 5; i++) data_tab[i] = 64'hC0DE000000000000 | 64'(i + 1);
    bus.drain_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_store(1'b1, 64'(10 + i) << 3, data_tab[i], 8'hFF);
      #1;
      checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL full_ready_%0d got=%0b exp=1", i, bus.st_ready); end
      tick();
    end
    drive_store(1'b1, 64'(14) << 3, data_tab[4], 8'hFF);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.st_ready !== 1'b0) begin failures++; $display("FAIL full_not_ready_%0d got=%0b exp=0", c, bus.st_ready); end
      checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL full_stalled_wr_%0d got=%0b exp=0", c, bus.dc_wr_en); end
      checks++; if (bus.dc_wr_data !== 64'd0) begin failures++; $display("FAIL full_stalled_data_%0d got=%h exp=0", c, bus.dc_wr_data); end
      tick();
    end
    bus.drain_stall = 1'b0;
    #1;
    // no full-with-pop bypass: still not ready while the first drain happens
    checks++; if (bus.st_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%0b exp=0", bus.st_ready); end
    checks++; if (bus.dc_wr_index !== 11'd10) begin failures++; $display("FAIL full_drain0_idx got=%0d exp=10", bus.dc_wr_index); end
    checks++; if (bus.dc_wr_data !== data_tab[0]) begin failures++; $display("FAIL full_drain0_data got=%h exp=%h", bus.dc_wr_data, data_tab[0]); end
    tick();
    #1;
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL full_ready_again got=%0b exp=1", bus.st_ready); end
    checks++; if (bus.dc_wr_index !== 11'd11) begin failures++; $display("FAIL full_drain1_idx got=%0d exp=11", bus.dc_wr_index); end
    checks++; if (bus.dc_wr_data !== data_tab[1]) begin failures++; $display("FAIL full_drain1_data got=%h exp=%h", bus.dc_wr_data, data_tab[1]); end
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    for (int j = 2; j < 5; j++) begin
      #1;
      checks++; if (bus.dc_wr_en !== 1'b1) begin failures++; $display("FAIL full_drain%0d_en got=%0b exp=1", j, bus.dc_wr_en); end
      checks++; if (bus.dc_wr_index !== 11'(10 + j)) begin failures++; $display("FAIL full_drain%0d_idx got=%0d exp=%0d", j, bus.dc_wr_index, 10 + j); end
      checks++; if (bus.dc_wr_data !== data_tab[j]) begin failures++; $display("FAIL full_drain%0d_data got=%h exp=%h", j, bus.dc_wr_data, data_tab[j]); end
      tick();
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%0b exp=1", bus.empty); end
  endtask

  task automatic test_partial_stall();
    bus.drain_stall = 1'b1;
    bus.dc_rd_data  = 64'h5555555555555555;
    drive_store(1'b1, 64'h18, 64'hA0A1A2A3A4A5A6A7, 8'hFF);
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b1, 64'h1C);
    #1;
    checks++; if (bus.ld_fwd_hit !== 1'b1) begin failures++; $display("FAIL part_single_hit got=%0b exp=1", bus.ld_fwd_hit); end
    checks++; if (bus.ld_fwd_data !== 64'hA0A1A2A3A4A5A6A7) begin failures++; $display("FAIL part_single_data got=%h exp=a0a1a2a3a4a5a6a7", bus.ld_fwd_data); end
    drive_load(1'b0, 64'd0);
    drive_store(1'b1, 64'h18, 64'h00000000000000B0, 8'h01);
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b1, 64'h1C);
    #1;
    checks++; if (bus.ld_stall !== 1'b1) begin failures++; $display("FAIL part_stall got=%0b exp=1", bus.ld_stall); end
    checks++; if (bus.ld_fwd_hit !== 1'b0) begin failures++; $display("FAIL part_no_hit got=%0b exp=0", bus.ld_fwd_hit); end
    bus.drain_stall = 1'b0;
    #1;
    checks++; if (bus.ld_stall !== 1'b1) begin failures++; $display("FAIL part_stall_drain0 got=%0b exp=1", bus.ld_stall); end
    checks++; if (bus.dc_wr_data !== 64'hA0A1A2A3A4A5A6A7) begin failures++; $display("FAIL part_drain0_data got=%h exp=a0a1a2a3a4a5a6a7", bus.dc_wr_data); end
    tick();
    checks++; if (bus.ld_stall !== 1'b1) begin failures++; $display("FAIL part_stall_drain1 got=%0b exp=1", bus.ld_stall); end
    checks++; if (bus.dc_wr_data !== 64'h55555555555555B0) begin failures++; $display("FAIL part_drain1_data got=%h exp=55555555555555b0", bus.dc_wr_data); end
    tick();
    checks++; if (bus.ld_stall !== 1'b0) begin failures++; $display("FAIL part_stall_clear got=%0b exp=0", bus.ld_stall); end
    checks++; if (bus.ld_fwd_hit !== 1'b0) begin failures++; $display("FAIL part_hit_clear got=%0b exp=0", bus.ld_fwd_hit); end
    drive_load(1'b0, 64'd0);
    bus.dc_rd_data = 64'd0;
  endtask

  task automatic test_forward();
    bus.drain_stall = 1'b1;
    drive_store(1'b1, 64'h28, 64'hC0C0C0C0C0C0C0C0, 8'hFF);
    tick();
    drive_store(1'b1, 64'h30, 64'hD0D0D0D0D0D0D0D0, 8'hFF);
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b1, 64'h28);
    #1;
    checks++; if (bus.ld_fwd_hit !== 1'b1) begin failures++; $display("FAIL fwd_hit5 got=%0b exp=1", bus.ld_fwd_hit); end
    checks++; if (bus.ld_fwd_data !== 64'hC0C0C0C0C0C0C0C0) begin failures++; $display("FAIL fwd_data5 got=%h exp=c0c0c0c0c0c0c0c0", bus.ld_fwd_data); end
    checks++; if (bus.ld_stall !== 1'b0) begin failures++; $display("FAIL fwd_stall5 got=%0b exp=0", bus.ld_stall); end
    drive_load(1'b1, 64'h30);
    #1;
    checks++; if (bus.ld_fwd_data !== 64'hD0D0D0D0D0D0D0D0) begin failures++; $display("FAIL fwd_data6 got=%h exp=d0d0d0d0d0d0d0d0", bus.ld_fwd_data); end
    drive_load(1'b1, 64'h38);
    #1;
    checks++; if (bus.ld_fwd_hit !== 1'b0 || bus.ld_stall !== 1'b0 || bus.ld_fwd_data !== 64'd0) begin failures++; $display("FAIL fwd_miss7 got=%0b/%0b/%h exp=0/0/0", bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_data); end
    // same-cycle store to the load's word: stall, and drop st_valid before the edge
    drive_load(1'b1, 64'h28);
    drive_store(1'b1, 64'h28, 64'h1, 8'hFF);
    #1;
    checks++; if (bus.ld_stall !== 1'b1) begin failures++; $display("FAIL fwd_st_conflict_stall got=%0b exp=1", bus.ld_stall); end
    checks++; if (bus.ld_fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_st_conflict_hit got=%0b exp=0", bus.ld_fwd_hit); end
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b0, 64'h28);
    #1;
    checks++; if (bus.ld_fwd_hit !== 1'b0 || bus.ld_fwd_data !== 64'd0) begin failures++; $display("FAIL fwd_ld_invalid got=%0b/%h exp=0/0", bus.ld_fwd_hit, bus.ld_fwd_data); end
    tick();
    // younger full-word store to index 5 wins
    drive_store(1'b1, 64'h28, 64'hE0E0E0E0E0E0E0E0, 8'hFF);
    tick();
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    drive_load(1'b1, 64'h2F);
    #1;
    checks++; if (bus.ld_fwd_data !== 64'hE0E0E0E0E0E0E0E0) begin failures++; $display("FAIL fwd_youngest got=%h exp=e0e0e0e0e0e0e0e0", bus.ld_fwd_data); end
    drive_load(1'b0, 64'd0);
    bus.drain_stall = 1'b0;
    repeat (3) tick();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fwd_empty got=%0b exp=1", bus.empty); end
  endtask

  task automatic test_reset_mid_drain();
    bus.drain_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_store(1'b1, 64'(20 + i) << 3, 64'hF00D0000 | 64'(i), 8'hFF);
      tick();
    end
    drive_store(1'b0, 64'd0, 64'd0, 8'h00);
    bus.drain_stall = 1'b0;
    #1;
    checks++; if (bus.dc_wr_en !== 1'b1) begin failures++; $display("FAIL mid_drain_active got=%0b exp=1", bus.dc_wr_en); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL mid_rst_wr_en got=%0b exp=0", bus.dc_wr_en); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty got=%0b exp=1", bus.empty); end
    tick();
    reset_n = 1'b1;
    drive_load(1'b1, 64'(21) << 3);
    #1;
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL mid_post_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.ld_fwd_hit !== 1'b0) begin failures++; $display("FAIL mid_post_hit got=%0b exp=0", bus.ld_fwd_hit); end
    checks++; if (bus.ld_stall !== 1'b0) begin failures++; $display("FAIL mid_post_stall got=%0b exp=0", bus.ld_stall); end
    checks++; if (bus.dc_wr_en !== 1'b0) begin failures++; $display("FAIL mid_post_wr_en got=%0b exp=0", bus.dc_wr_en); end
    drive_load(1'b0, 64'd0);
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_store();
    test_merge();
    test_full_stall();
    test_partial_stall();
    test_forward();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
